// File: rtl/multicycle_main_fsm.sv
// ============================================================================
// multicycle_main_fsm
// ----------------------------------------------------------------------------
// Main control state machine for the multicycle RISC-V datapath. Each
// instruction walks through FETCH -> DECODE -> (execute / memory states) ->
// writeback, and the controller drives the shared ALU, memory and register
// file control signals as Moore outputs of the current state.
//
// Memory states (FETCH, MEMREAD, MEMWRITE) are stretched by MEM_WAIT extra
// cycles; the memory-side strobes (irWrite, pcUpdate, memWrite) fire only on
// the final cycle of the stretch. Opcodes that are not recognised (or whose
// instruction class is disabled by parameter) land in TRAP, which holds until
// reset and raises the sticky trap flag.
//
// Parameters:
//   MEM_WAIT  extra cycles per memory access, 0..15
//   EN_ITYPE  1 = op 19 (I-type ALU) is legal
//   EN_JAL    1 = op 111 (jal) is legal
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   op[6:0]    in   opcode from the instruction register
//   zero       in   ALU zero flag
//   pcWrite    out  pcUpdate | (branch & zero)
//   adrSrc     out  memory address: 0 = PC, 1 = ALU result register
//   memWrite   out  data memory write strobe
//   irWrite    out  instruction register load
//   regWrite   out  register file write
//   resultSrc  out  00 ALUOut, 01 read data, 10 ALU result
//   aluSrcA    out  00 PC, 01 oldPC, 10 rs1 data
//   aluSrcB    out  00 rs2 data, 01 immediate, 10 constant 4
//   aluOp      out  00 add, 01 subtract, 10 funct-decoded
//   immSrc     out  immediate format, combinational from op
//   trap       out  sticky illegal-opcode flag
//   state      out  current state encoding (debug)
//
// Write strobes (pcWrite, memWrite, irWrite, regWrite) are forced low while
// reset is high so no partial strobe escapes during a mid-instruction reset.
// ============================================================================
module multicycle_main_fsm #(
    parameter int   MEM_WAIT = 0,
    parameter logic EN_ITYPE = 1'b1,
    parameter logic EN_JAL   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] immSrc,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state_q;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       trap_q;
    logic       wait_done;
    logic       in_mem;
    logic       pc_update;
    logic       branch;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;

    // ------------------------------------------------------------------
    // State, wait counter and trap flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_cnt <= 4'd0;
            trap_q   <= 1'b0;
        end else begin
            state_q <= state_next;
            // Counter restarts whenever the state changes, so every memory
            // state is entered with a count of 0. It stops on the final
            // cycle and therefore never wraps.
            if (state_next != state_q) begin
                wait_cnt <= 4'd0;
            end else if (in_mem && !wait_done) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (state_next == S_TRAP) begin
                trap_q <= 1'b1;
            end
        end
    end

    assign wait_done = (wait_cnt == WAIT_LAST);
    assign in_mem    = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE);

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_q;
        pc_update     = 1'b0;
        branch        = 1'b0;
        adrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        resultSrc     = 2'b00;
        aluSrcA       = 2'b00;
        aluSrcB       = 2'b00;
        aluOp         = 2'b00;

        case (state_q)
            S_FETCH: begin
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                if (wait_done) begin
                    ir_write_raw = 1'b1;
                    pc_update    = 1'b1;
                    state_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (op)
                    7'd3, 7'd35: state_next = S_MEMADR;
                    7'd51:       state_next = S_EXECR;
                    7'd99:       state_next = S_BEQ;
                    7'd19:       state_next = EN_ITYPE ? S_EXECI : S_TRAP;
                    7'd111:      state_next = EN_JAL   ? S_JAL   : S_TRAP;
                    default:     state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                aluSrcA    = 2'b10;
                aluSrcB    = 2'b01;
                state_next = (op == 7'd35) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrSrc = 1'b1;
                if (wait_done) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                resultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                adrSrc = 1'b1;
                if (wait_done) begin
                    mem_write_raw = 1'b1;
                    state_next    = S_FETCH;
                end
            end
            S_EXECR: begin
                aluSrcA    = 2'b10;
                aluOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                aluSrcA    = 2'b10;
                aluSrcB    = 2'b01;
                aluOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_next    = S_FETCH;
            end
            S_JAL: begin
                aluSrcA    = 2'b01;
                aluSrcB    = 2'b10;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            S_BEQ: begin
                aluSrcA    = 2'b10;
                aluOp      = 2'b01;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Immediate format straight from the opcode.
    always_comb begin
        case (op)
            7'd35:   immSrc = 2'b01;
            7'd99:   immSrc = 2'b10;
            7'd111:  immSrc = 2'b11;
            default: immSrc = 2'b00;
        endcase
    end

    assign pcWrite  = !reset && (pc_update || (branch && zero));
    assign memWrite = !reset && mem_write_raw;
    assign irWrite  = !reset && ir_write_raw;
    assign regWrite = !reset && reg_write_raw;
    assign trap     = trap_q;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// ============================================================================
// tb_multicycle_main_fsm
// ----------------------------------------------------------------------------
// Two controllers run side by side from independent stimulus:
//   dut 0: MEM_WAIT=2, I-type legal, jal illegal
//   dut 1: MEM_WAIT=0, I-type illegal, jal legal
// Each driver expands an instruction into its per-cycle state walk from the
// instruction's cycle budget and pushes one expected output word per cycle.
// A monitor on the falling edge pops and compares the whole output bundle.
// ============================================================================
module tb_multicycle_main_fsm;

    localparam int W0 = 2;
    localparam int W1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s  [2];
    logic [6:0] op_s   [2];
    logic       zero_s [2];

    logic       pcw_0, adr_0, mw_0, irw_0, rw_0, trap_0;
    logic [1:0] rs_0, sa_0, sb_0, aop_0, imm_0;
    logic [3:0] st_0;
    logic       pcw_1, adr_1, mw_1, irw_1, rw_1, trap_1;
    logic [1:0] rs_1, sa_1, sb_1, aop_1, imm_1;
    logic [3:0] st_1;

    logic [19:0] exp_q0[$];
    logic [19:0] exp_q1[$];

    int checks = 0;
    int errors = 0;

    multicycle_main_fsm #(.MEM_WAIT(W0), .EN_ITYPE(1'b1), .EN_JAL(1'b0)) dut0 (
        .clk(clk), .reset(rst_s[0]), .op(op_s[0]), .zero(zero_s[0]),
        .pcWrite(pcw_0), .adrSrc(adr_0), .memWrite(mw_0), .irWrite(irw_0),
        .regWrite(rw_0), .resultSrc(rs_0), .aluSrcA(sa_0), .aluSrcB(sb_0),
        .aluOp(aop_0), .immSrc(imm_0), .trap(trap_0), .state(st_0)
    );

    multicycle_main_fsm #(.MEM_WAIT(W1), .EN_ITYPE(1'b0), .EN_JAL(1'b1)) dut1 (
        .clk(clk), .reset(rst_s[1]), .op(op_s[1]), .zero(zero_s[1]),
        .pcWrite(pcw_1), .adrSrc(adr_1), .memWrite(mw_1), .irWrite(irw_1),
        .regWrite(rw_1), .resultSrc(rs_1), .aluSrcA(sa_1), .aluSrcB(sb_1),
        .aluOp(aop_1), .immSrc(imm_1), .trap(trap_1), .state(st_1)
    );

    // Expected output word for one cycle, from the per-state output table.
    // Layout: {state, pcWrite, adrSrc, memWrite, irWrite, regWrite,
    //          resultSrc, aluSrcA, aluSrcB, aluOp, immSrc, trap}
    function automatic logic [19:0] ev(input int st, input bit fin,
                                       input logic [6:0] op, input bit z,
                                       input bit trapf, input bit rst);
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, aop, imm;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
        rs = 0; sa = 0; sb = 0; aop = 0; imm = 0;
        case (st)
            0:  begin sb = 2; rs = 2; irw = fin; pcw = fin; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  begin adr = 1; end
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = fin; end
            6:  begin sa = 2; aop = 2; end
            7:  begin rw = 1; end
            8:  begin sa = 2; sb = 1; aop = 2; end
            9:  begin sa = 1; sb = 2; pcw = 1; end
            10: begin sa = 2; aop = 1; pcw = z; end
            default: ;
        endcase
        if (op == 7'd35)       imm = 2'b01;
        else if (op == 7'd99)  imm = 2'b10;
        else if (op == 7'd111) imm = 2'b11;
        if (rst) begin pcw = 0; mw = 0; irw = 0; rw = 0; end
        return {4'(st), pcw, adr, mw, irw, rw, rs, sa, sb, aop, imm, trapf};
    endfunction

    function automatic bit rz();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle of stimulus plus its expected response.
    task automatic cyc(input int k, input int st, input bit fin, input bit rst,
                       input logic [6:0] op, input bit z, input bit trapf);
        @(posedge clk);
        #1;
        rst_s[k]  = rst;
        op_s[k]   = op;
        zero_s[k] = z;
        if (k == 0) exp_q0.push_back(ev(st, fin, op, z, trapf, rst));
        else        exp_q1.push_back(ev(st, fin, op, z, trapf, rst));
    endtask

    // Hold reset for a few edges; the last reset cycle is checked in FETCH.
    task automatic do_reset(input int k);
        int w;
        w = (k == 0) ? W0 : W1;
        rst_s[k] = 1'b1; op_s[k] = 7'd0; zero_s[k] = 1'b0;
        repeat (2) @(posedge clk);
        cyc(k, 0, w == 0, 1, 7'd0, rz(), 0);
    endtask

    task automatic fetch_decode(input int k, input logic [6:0] op);
        int w;
        w = (k == 0) ? W0 : W1;
        for (int i = 0; i <= w; i++) cyc(k, 0, i == w, 0, op, rz(), 0);
        cyc(k, 1, 0, 0, op, rz(), 0);
    endtask

    // Full instruction. Illegal opcodes sit in TRAP for 20 cycles, then
    // reset is asserted for one cycle so the next instruction starts clean.
    task automatic instr(input int k, input logic [6:0] op, input bit z);
        int w;
        bit en_i, en_j;
        w    = (k == 0) ? W0 : W1;
        en_i = (k == 0);
        en_j = (k == 1);
        fetch_decode(k, op);
        if (op == 7'd3) begin
            cyc(k, 2, 0, 0, op, rz(), 0);
            for (int i = 0; i <= w; i++) cyc(k, 3, i == w, 0, op, rz(), 0);
            cyc(k, 4, 0, 0, op, rz(), 0);
        end else if (op == 7'd35) begin
            cyc(k, 2, 0, 0, op, rz(), 0);
            for (int i = 0; i <= w; i++) cyc(k, 5, i == w, 0, op, rz(), 0);
        end else if (op == 7'd51) begin
            cyc(k, 6, 0, 0, op, rz(), 0);
            cyc(k, 7, 0, 0, op, rz(), 0);
        end else if (op == 7'd19 && en_i) begin
            cyc(k, 8, 0, 0, op, rz(), 0);
            cyc(k, 7, 0, 0, op, rz(), 0);
        end else if (op == 7'd111 && en_j) begin
            cyc(k, 9, 0, 0, op, rz(), 0);
            cyc(k, 7, 0, 0, op, rz(), 0);
        end else if (op == 7'd99) begin
            cyc(k, 10, 0, 0, op, z, 0);
        end else begin
            for (int i = 0; i < 20; i++) cyc(k, 11, 0, 0, op, rz(), 1);
            cyc(k, 11, 0, 1, op, rz(), 1);
        end
    endtask

    // lw interrupted by reset on the second MEMREAD cycle (count 1).
    task automatic lw_reset_mid_wait(input int k);
        fetch_decode(k, 7'd3);
        cyc(k, 2, 0, 0, 7'd3, rz(), 0);
        cyc(k, 3, 0, 0, 7'd3, rz(), 0);
        cyc(k, 3, 0, 1, 7'd3, rz(), 0);
    endtask

    task automatic drive0();
        logic [6:0] ops[5];
        ops[0] = 7'd3; ops[1] = 7'd35; ops[2] = 7'd51; ops[3] = 7'd19; ops[4] = 7'd99;
        do_reset(0);
        instr(0, 7'd3, 0);
        instr(0, 7'd35, 0);
        instr(0, 7'd99, 1);
        instr(0, 7'd99, 0);
        instr(0, 7'd51, 0);
        instr(0, 7'd19, 0);
        lw_reset_mid_wait(0);
        instr(0, 7'd3, 0);
        for (int n = 0; n < 30; n++) instr(0, ops[$urandom_range(0, 4)], rz());
        instr(0, 7'd111, 0);
        instr(0, 7'd35, 0);
        instr(0, 7'd0, 0);
        instr(0, 7'd51, 0);
    endtask

    task automatic drive1();
        logic [6:0] ops[5];
        ops[0] = 7'd3; ops[1] = 7'd35; ops[2] = 7'd51; ops[3] = 7'd111; ops[4] = 7'd99;
        do_reset(1);
        instr(1, 7'd3, 0);
        instr(1, 7'd111, 0);
        instr(1, 7'd35, 0);
        instr(1, 7'd99, 1);
        for (int n = 0; n < 30; n++) instr(1, ops[$urandom_range(0, 4)], rz());
        instr(1, 7'd19, 0);
        instr(1, 7'd99, 0);
        instr(1, 7'd127, 0);
        instr(1, 7'd3, 0);
    endtask

    // Monitor: one comparison per DUT per cycle once stimulus is flowing.
    always @(negedge clk) begin
        logic [19:0] e, a;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            a = {st_0, pcw_0, adr_0, mw_0, irw_0, rw_0, rs_0, sa_0, sb_0, aop_0, imm_0, trap_0};
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL dut0_outputs t=%0t got %b exp %b (state %0d vs %0d)",
                         $time, a, e, a[19:16], e[19:16]);
            end
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            a = {st_1, pcw_1, adr_1, mw_1, irw_1, rw_1, rs_1, sa_1, sb_1, aop_1, imm_1, trap_1};
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL dut1_outputs t=%0t got %b exp %b (state %0d vs %0d)",
                         $time, a, e, a[19:16], e[19:16]);
            end
        end
    end

    initial begin
        rst_s[0] = 1'b1; op_s[0] = 7'd0; zero_s[0] = 1'b0;
        rst_s[1] = 1'b1; op_s[1] = 7'd0; zero_s[1] = 1'b0;
        fork
            drive0();
            drive1();
        join
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            errors = errors + 1;
            $display("FAIL queue_drain left %0d required 0", exp_q0.size() + exp_q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time %0t reached before end of stimulus", $time);
        $fatal(1, "watchdog");
    end

endmodule
